// File: rtl/fft_pkg.sv
// Shared constants, control-word layout and bit-reversal helper for the
// 8-point radix-2 DIT FFT sequencer.
package fft_pkg;

  localparam int N     = 8;
  localparam int LOG2N = $clog2(N);

  typedef logic [LOG2N-1:0] addr_t;

  localparam logic [2:0] PH_IDLE   = 3'd0;
  localparam logic [2:0] PH_LOAD   = 3'd1;
  localparam logic [2:0] PH_STG0   = 3'd2;
  localparam logic [2:0] PH_STG1   = 3'd3;
  localparam logic [2:0] PH_STG2   = 3'd4;
  localparam logic [2:0] PH_UNLOAD = 3'd5;

  // One registered control word: every strobe, address and twiddle index.
  typedef struct packed {
    logic       ld_en;
    addr_t      ld_addr;
    logic       rd_en;
    addr_t      rd_addr_a;
    addr_t      rd_addr_b;
    logic       wr_en;
    addr_t      wr_addr_a;
    addr_t      wr_addr_b;
    logic [1:0] tw_idx;
    logic       ul_en;
    addr_t      ul_addr;
  } ctl_t;

  function automatic addr_t bitrev3(input addr_t x);
    return {x[0], x[1], x[2]};
  endfunction

endpackage

// File: rtl/fft8_bf_addr.sv
// Butterfly operand addresses and twiddle index for stage s, butterfly k:
// span=2^s, a=(k>>s)*2*span+(k mod span), b=a+span, tw=(k mod span)<<(2-s).
module fft8_bf_addr (
  input  logic [1:0] stage,
  input  logic [1:0] k,
  output logic [2:0] addr_a,
  output logic [2:0] addr_b,
  output logic [1:0] tw_idx
);

  always_comb begin
    addr_a = '0;
    addr_b = '0;
    tw_idx = '0;
    case (stage)
      2'd0: begin
        addr_a = {k, 1'b0};
        addr_b = {k, 1'b1};
      end
      2'd1: begin
        addr_a = {k[1], 1'b0, k[0]};
        addr_b = {k[1], 1'b1, k[0]};
        tw_idx = {k[0], 1'b0};
      end
      2'd2: begin
        addr_a = {1'b0, k};
        addr_b = {1'b1, k};
        tw_idx = k;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fft8_seq.sv
// Load/compute/unload sequencer for an 8-point FFT, paced by an external
// modulo-9 index counter; all strobes and addresses are registered.
module fft8_seq
  import fft_pkg::*;
(
  input  logic       clk,
  input  logic       sclr_n,
  input  logic       start,
  input  logic [2:0] idx,
  input  logic       idx_wrap,
  output logic       cnt_clr,
  output logic [2:0] phase,
  output logic       ld_en,
  output logic [2:0] ld_addr,
  output logic       rd_en,
  output logic [2:0] rd_addr_a,
  output logic [2:0] rd_addr_b,
  output logic       wr_en,
  output logic [2:0] wr_addr_a,
  output logic [2:0] wr_addr_b,
  output logic [1:0] tw_idx,
  output logic       ul_en,
  output logic [2:0] ul_addr,
  output logic       busy,
  output logic       done
);

  logic [2:0] state, state_nxt;
  logic [1:0] stage;
  addr_t      bf_a, bf_b;
  logic [1:0] bf_tw;
  ctl_t       ctl_d, ctl_q;

  always_comb begin
    state_nxt = state;
    case (state)
      PH_IDLE:   if (start)    state_nxt = PH_LOAD;
      PH_LOAD:   if (idx_wrap) state_nxt = PH_STG0;
      PH_STG0:   if (idx_wrap) state_nxt = PH_STG1;
      PH_STG1:   if (idx_wrap) state_nxt = PH_STG2;
      PH_STG2:   if (idx_wrap) state_nxt = PH_UNLOAD;
      PH_UNLOAD: if (idx_wrap) state_nxt = PH_IDLE;
      default:                 state_nxt = PH_IDLE;
    endcase
  end

  always_comb begin
    case (state)
      PH_STG1: stage = 2'd1;
      PH_STG2: stage = 2'd2;
      default: stage = 2'd0;
    endcase
  end

  // Reads and write-backs share one address generator: same stage, same k.
  fft8_bf_addr u_bf (
    .stage  (stage),
    .k      (idx[1:0]),
    .addr_a (bf_a),
    .addr_b (bf_b),
    .tw_idx (bf_tw)
  );

  always_comb begin
    ctl_d = '0;
    if (!idx_wrap) begin
      case (state)
        PH_LOAD: begin
          ctl_d.ld_en   = 1'b1;
          ctl_d.ld_addr = bitrev3(idx);
        end
        PH_STG0, PH_STG1, PH_STG2: begin
          if (!idx[2]) begin
            ctl_d.rd_en     = 1'b1;
            ctl_d.rd_addr_a = bf_a;
            ctl_d.rd_addr_b = bf_b;
            ctl_d.tw_idx    = bf_tw;
          end else begin
            ctl_d.wr_en     = 1'b1;
            ctl_d.wr_addr_a = bf_a;
            ctl_d.wr_addr_b = bf_b;
          end
        end
        PH_UNLOAD: begin
          ctl_d.ul_en   = 1'b1;
          ctl_d.ul_addr = idx;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      state <= PH_IDLE;
      ctl_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      ctl_q <= ctl_d;
      busy  <= (state_nxt != PH_IDLE);
      done  <= (state == PH_UNLOAD) && idx_wrap;
    end
  end

  assign cnt_clr   = !sclr_n || (state == PH_IDLE);
  assign phase     = state;
  assign ld_en     = ctl_q.ld_en;
  assign ld_addr   = ctl_q.ld_addr;
  assign rd_en     = ctl_q.rd_en;
  assign rd_addr_a = ctl_q.rd_addr_a;
  assign rd_addr_b = ctl_q.rd_addr_b;
  assign wr_en     = ctl_q.wr_en;
  assign wr_addr_a = ctl_q.wr_addr_a;
  assign wr_addr_b = ctl_q.wr_addr_b;
  assign tw_idx    = ctl_q.tw_idx;
  assign ul_en     = ctl_q.ul_en;
  assign ul_addr   = ctl_q.ul_addr;

endmodule

// File: tb/tb_fft8_seq.sv
// Directed bench for fft8_seq driven by a modulo-9 index counter model;
// expected per-cycle outputs come from hand-written address tables.
module tb_fft8_seq;

  logic       clk = 1'b0;
  logic       sclr_n, start;
  logic [2:0] idx;
  logic       idx_wrap, cnt_clr;
  logic [2:0] phase;
  logic       ld_en, rd_en, wr_en, ul_en, busy, done;
  logic [2:0] ld_addr, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, ul_addr;
  logic [1:0] tw_idx;
  logic [3:0] cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Hand-computed expectations.
  int ld_exp[8]   = '{0, 4, 2, 6, 1, 5, 3, 7};
  int ra_exp[3][4] = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
  int rb_exp[3][4] = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
  int tw_exp[3][4] = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};
  int wcnt[8];

  always #5 clk = ~clk;

  // Modulo-9 index counter: out/cout feed idx/idx_wrap, cnt_clr is its sclr.
  always_ff @(posedge clk) begin
    if (cnt_clr) cnt <= 4'd0;
    else         cnt <= (cnt == 4'd8) ? 4'd0 : cnt + 4'd1;
  end
  assign idx      = cnt[2:0];
  assign idx_wrap = (cnt == 4'd8);

  fft8_seq dut (
    .clk       (clk),
    .sclr_n    (sclr_n),
    .start     (start),
    .idx       (idx),
    .idx_wrap  (idx_wrap),
    .cnt_clr   (cnt_clr),
    .phase     (phase),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .tw_idx    (tw_idx),
    .ul_en     (ul_en),
    .ul_addr   (ul_addr),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  always @(negedge clk)
    if (sclr_n === 1'b1) chk("onehot0", $onehot0({ld_en, rd_en, wr_en, ul_en}), 1);

  task automatic chk_quiet(input string tag);
    chk({tag, "_ph"},   phase, 0);
    chk({tag, "_clr"},  cnt_clr, 1);
    chk({tag, "_strb"}, {ld_en, rd_en, wr_en, ul_en}, 0);
    chk({tag, "_addr"}, {ld_addr, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, ul_addr, tw_idx}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Start a pass and check every cycle; extra_start re-pulses start at that cycle.
  task automatic run_pass(input int extra_start);
    int ph, off, j, s;
    int e_ld, e_lda, e_rd, e_ra, e_rb, e_tw, e_wr, e_wa, e_wb, e_ul, e_ua;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      ph  = (c <= 45) ? (c - 1) / 9 + 1 : 0;
      off = (c - 1) % 9;
      j   = off - 1;
      {e_ld, e_lda, e_rd, e_ra, e_rb, e_tw, e_wr, e_wa, e_wb, e_ul, e_ua} = '0;
      if (ph != 0 && off >= 1) begin
        case (ph)
          1: begin e_ld = 1; e_lda = ld_exp[j]; end
          5: begin e_ul = 1; e_ua = j; end
          default: begin
            s = ph - 2;
            if (j < 4) begin
              e_rd = 1; e_ra = ra_exp[s][j]; e_rb = rb_exp[s][j]; e_tw = tw_exp[s][j];
            end else begin
              e_wr = 1; e_wa = ra_exp[s][j-4]; e_wb = rb_exp[s][j-4];
            end
          end
        endcase
      end
      chk($sformatf("phase@%0d", c),   phase, ph);
      chk($sformatf("cnt_clr@%0d", c), cnt_clr, (ph == 0) ? 1 : 0);
      chk($sformatf("ld_en@%0d", c),   ld_en, e_ld);
      chk($sformatf("ld_addr@%0d", c), ld_addr, e_lda);
      chk($sformatf("rd_en@%0d", c),   rd_en, e_rd);
      chk($sformatf("rd_a@%0d", c),    rd_addr_a, e_ra);
      chk($sformatf("rd_b@%0d", c),    rd_addr_b, e_rb);
      chk($sformatf("tw@%0d", c),      tw_idx, e_tw);
      chk($sformatf("wr_en@%0d", c),   wr_en, e_wr);
      chk($sformatf("wr_a@%0d", c),    wr_addr_a, e_wa);
      chk($sformatf("wr_b@%0d", c),    wr_addr_b, e_wb);
      chk($sformatf("ul_en@%0d", c),   ul_en, e_ul);
      chk($sformatf("ul_addr@%0d", c), ul_addr, e_ua);
      chk($sformatf("busy@%0d", c),    busy, (c <= 45) ? 1 : 0);
      chk($sformatf("done@%0d", c),    done, (c == 46) ? 1 : 0);
      if (wr_en) begin
        wcnt[wr_addr_a]++;
        wcnt[wr_addr_b]++;
      end
      if (c == 18 || c == 27 || c == 36) begin
        for (int a = 0; a < 8; a++) begin
          chk($sformatf("wr_once@%0d_a%0d", c, a), wcnt[a], 1);
          wcnt[a] = 0;
        end
      end
      start = (c == extra_start);
    end
    start = 1'b0;
  endtask

  initial begin
    sclr_n = 1'b0;
    start  = 1'b0;
    for (int a = 0; a < 8; a++) wcnt[a] = 0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk_quiet("reset");
    start  = 1'b0;
    sclr_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_quiet("idle");

    run_pass(0);
    run_pass(12);   // start during STG0 is ignored
    run_pass(45);   // start on the UNLOAD->IDLE edge is ignored

    // Reset mid-STG1, then a clean pass.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (23) @(negedge clk);
    chk("pre_rst_ph", phase, 3);
    sclr_n = 1'b0;
    @(negedge clk);
    chk_quiet("midrst");
    sclr_n = 1'b1;
    @(negedge clk);
    chk_quiet("postrst");
    for (int a = 0; a < 8; a++) wcnt[a] = 0;
    run_pass(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft8_seq.md
FFT8_SEQ -- requirements
Module: fft8_seq

Interface
REQ-001 Parameters: none; the block is fixed to an 8-point radix-2 DIT FFT (3 stages of 4 butterflies each).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 sclr_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  one-cycle request to run a full load/compute/unload pass.
REQ-005 idx  input  3  sample/butterfly index from the modulo-9 index counter.
REQ-006 idx_wrap  input  1  index-counter carry; high on the counter's 9th count, when idx=0.
REQ-007 cnt_clr  output  1  synchronous clear driven to the index counter.
REQ-008 phase  output  3  current phase: 0 IDLE, 1 LOAD, 2 STG0, 3 STG1, 4 STG2, 5 UNLOAD.
REQ-009 ld_en, ld_addr  output  1, 3  input-sample write strobe and bit-reversed RAM address.
REQ-010 rd_en, rd_addr_a, rd_addr_b  output  1, 3, 3  butterfly operand read strobe and addresses.
REQ-011 wr_en, wr_addr_a, wr_addr_b  output  1, 3, 3  butterfly result write-back strobe and addresses.
REQ-012 tw_idx  output  2  twiddle index k for W8^k, valid with rd_en.
REQ-013 ul_en, ul_addr  output  1, 3  natural-order output read strobe and address.
REQ-014 busy, done  output  1, 1  busy: pass in progress; done: one-cycle pulse at pass end.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, STG0, STG1, STG2, UNLOAD; phase SHALL equal the state encoding (combinational).
REQ-016 cnt_clr SHALL be combinational: 1 when sclr_n=0 or state=IDLE, else 0.
REQ-017 In IDLE, start=1 SHALL move the state to LOAD at the next edge; start in any other state SHALL be ignored.
REQ-018 In each non-IDLE state, an edge with idx_wrap=1 SHALL advance the state LOAD->STG0->STG1->STG2->UNLOAD->IDLE; each phase therefore lasts 9 cycles, and a full pass lasts 45 cycles.
REQ-019 Active cycles are those with idx_wrap=0. Every strobe, address and tw_idx SHALL be registered: outputs SHALL reflect the state and idx sampled at the previous edge (latency 1).
REQ-020 LOAD active: ld_en=1 and ld_addr=bitrev3(idx), e.g. idx 1->4 and idx 3->6.
REQ-021 STGs active with idx[2]=0: rd_en=1 and k=idx[1:0]. With span=2^s, rd_addr_a=(k>>s)*2*span+(k mod span), rd_addr_b=rd_addr_a+span, tw_idx=(k mod span)<<(2-s).
REQ-022 STGs active with idx[2]=1: wr_en=1 and wr addresses = the REQ-021 formula applied to k=idx[1:0]; this gives a fixed butterfly latency of 4 cycles.
REQ-023 UNLOAD active: ul_en=1 and ul_addr=idx.
REQ-024 On idx_wrap=1 cycles and in IDLE, all strobes SHALL be 0 on the next cycle, and addresses and tw_idx SHALL hold 0.
REQ-025 busy SHALL be registered: 1 from the cycle after start is accepted until the edge leaving UNLOAD.
REQ-026 done SHALL be 1 for exactly the one cycle following the UNLOAD->IDLE transition.
REQ-027 At most one of ld_en, rd_en, wr_en and ul_en SHALL be high in any cycle.
REQ-028 start coincident with the UNLOAD->IDLE edge SHALL be ignored; a new pass SHALL need start while in IDLE.

Reset
REQ-029 sclr_n=0 at an edge SHALL force IDLE and clear every registered output to 0 (busy=0, done=0); this applies mid-pass as well.
REQ-030 cnt_clr SHALL be 1 throughout reset, so the index counter returns to 0 together with the FSM.
REQ-031 A reset edge SHALL take priority over start and idx_wrap.

Structure
REQ-032 A shared package fft_pkg SHALL hold N=8, LOG2N=3, the phase encoding constants and the bitrev3 function.
REQ-033 The butterfly address and twiddle computation (REQ-021/022) SHALL be a combinational sub-module fft8_bf_addr with inputs stage and k and outputs addr_a, addr_b and tw_idx.
REQ-034 The benches SHALL connect the block to the team's modulo-9 index counter: cnt_clr to its sclr, and its out/cout to idx/idx_wrap.

Verification
REQ-035 Reset, then start pulse -> phase 1 on the next cycle; ld_addr sequence 0,4,2,6,1,5,3,7; done high 46 cycles after start.
REQ-036 STG1 -> rd pairs (0,2),(1,3),(4,6),(5,7) with tw 0,2,0,2; wr pairs repeat 4 cycles later.
REQ-037 STG2 -> rd pairs (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3; STG0 pairs (0,1),(2,3),(4,5),(6,7) with tw 0.
REQ-038 start re-pulsed during STG0 -> no effect; pass length stays 45 cycles, single done pulse.
REQ-039 sclr_n=0 for one cycle mid-STG1 -> phase 0, all strobes 0, busy 0, cnt_clr 1; a following start yields a clean full pass.
REQ-040 Every cycle of a full pass -> assertion checks strobe one-hot-or-zero, and every RAM address is written exactly once per stage.
